// File: rtl/way_alloc_unit.sv
// rtl/way_alloc_unit.sv - per-set valid/true-LRU way allocation and replacement unit
//
// Purpose:
//   Keeps one valid bit and one true-LRU age per way for every set, and serves
//   ALLOC / TOUCH / INVAL / QUERY requests at one per cycle with a one-cycle
//   registered response. After reset an INIT sweep writes every set to
//   "all invalid, age[w] = w" before requests are accepted.
//
// Optional feature macro: ALLOC_PERF_CNT_EN
//   When defined, adds the saturating allocation counters cnt_fill_empty_o and
//   cnt_evict_o. When undefined, those ports and registers are absent.
//
// Ports:
//   clk_i             clock, rising edge
//   rst_ni            asynchronous active-low reset
//   req_valid_i       request present
//   req_ready_o       unit accepts a request this cycle (low during INIT)
//   req_op_i          00 ALLOC, 01 TOUCH, 10 INVAL, 11 QUERY
//   req_index_i       set index
//   req_way_i         target way for TOUCH / INVAL
//   rsp_valid_o       one-cycle response strobe
//   rsp_way_o         chosen or queried way (held until next response)
//   rsp_empty_o       chosen way was invalid before the op
//   rsp_evict_o       ALLOC displaced a valid way
//   cnt_fill_empty_o  ALLOCs served from an empty way (ALLOC_PERF_CNT_EN)
//   cnt_evict_o       ALLOCs that evicted a valid way (ALLOC_PERF_CNT_EN)

module way_alloc_unit #(
  parameter int NUM_WAYS = 8,
  parameter int NUM_SETS = 1024,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [IDX_W-1:0] req_index_i,
  input  logic [WAY_W-1:0] req_way_i,
  output logic             rsp_valid_o,
  output logic [WAY_W-1:0] rsp_way_o,
  output logic             rsp_empty_o,
  output logic             rsp_evict_o
`ifdef ALLOC_PERF_CNT_EN
  ,
  output logic [31:0]      cnt_fill_empty_o,
  output logic [31:0]      cnt_evict_o
`endif
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam logic [1:0]       OP_ALLOC = 2'b00;
  localparam logic [1:0]       OP_TOUCH = 2'b01;
  localparam logic [1:0]       OP_INVAL = 2'b10;
  localparam logic [1:0]       OP_QUERY = 2'b11;
  localparam logic [WAY_W-1:0] AGE_LRU  = WAY_W'(NUM_WAYS - 1);
  localparam logic [IDX_W-1:0] SET_LAST = IDX_W'(NUM_SETS - 1);

  // Per-set state arrays. These are initialised by the INIT sweep rather than
  // by reset, so they live in a reset-free clocked block.
  logic [NUM_WAYS-1:0]            valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0][WAY_W-1:0] age_q   [NUM_SETS];

  // Control and response registers.
  state_e           state_q;
  logic [IDX_W-1:0] set_cnt_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [WAY_W-1:0] rsp_way_q;
  logic             rsp_empty_q;
  logic             rsp_evict_q;

  // Combinational lookup / next-row signals.
  logic                           accept;
  logic [NUM_WAYS-1:0]            row_valid;
  logic [NUM_WAYS-1:0][WAY_W-1:0] row_age;
  logic                           any_empty;
  logic [WAY_W-1:0]               empty_way;
  logic [WAY_W-1:0]               victim_way;
  logic [WAY_W-1:0]               tgt_way;
  logic [WAY_W-1:0]               tgt_age;
  logic [NUM_WAYS-1:0]            row_valid_d;
  logic [NUM_WAYS-1:0][WAY_W-1:0] row_age_d;
  logic                           row_wr;
  logic                           rsp_empty_d;
  logic                           rsp_evict_d;
  logic [NUM_WAYS-1:0][WAY_W-1:0] init_age;

  assign accept    = req_valid_i & req_ready_q;
  assign row_valid = valid_q[req_index_i];
  assign row_age   = age_q[req_index_i];
  assign any_empty = ~(&row_valid);

  // Reset image of a set: way w starts with age w.
  always_comb begin
    init_age = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      init_age[w] = WAY_W'(w);
    end
  end

  // Lowest-numbered invalid way: scanning downward lets the lowest index win.
  always_comb begin
    empty_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!row_valid[w]) begin
        empty_way = WAY_W'(w);
      end
    end
  end

  // Ages form a permutation, so exactly one way holds the LRU age.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (row_age[w] == AGE_LRU) begin
        victim_way = WAY_W'(w);
      end
    end
  end

  // ALLOC and QUERY share the empty-else-victim choice; TOUCH and INVAL
  // address the requested way directly.
  always_comb begin
    if (req_op_i == OP_TOUCH || req_op_i == OP_INVAL) begin
      tgt_way = req_way_i;
    end else if (any_empty) begin
      tgt_way = empty_way;
    end else begin
      tgt_way = victim_way;
    end
  end

  assign tgt_age = row_age[tgt_way];

  // For every opcode "was the target invalid before the op" is the empty flag:
  // an ALLOC/QUERY target is the empty way when one exists, else a valid victim.
  assign rsp_empty_d = ~row_valid[tgt_way];
  assign rsp_evict_d = (req_op_i == OP_ALLOC) & ~any_empty;
  assign row_wr      = accept & (req_op_i != OP_QUERY);

  // Next contents of the addressed set.
  always_comb begin
    row_valid_d = row_valid;
    row_age_d   = row_age;
    case (req_op_i)
      OP_ALLOC, OP_TOUCH: begin
        // Promote to MRU: ways younger than the target age by one.
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == tgt_way) begin
            row_age_d[w] = '0;
          end else if (row_age[w] < tgt_age) begin
            row_age_d[w] = row_age[w] + 1'b1;
          end
        end
        if (req_op_i == OP_ALLOC) begin
          row_valid_d[tgt_way] = 1'b1;
        end
      end
      OP_INVAL: begin
        // Demote to LRU: ways older than the target get one step younger.
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == tgt_way) begin
            row_age_d[w] = AGE_LRU;
          end else if (row_age[w] > tgt_age) begin
            row_age_d[w] = row_age[w] - 1'b1;
          end
        end
        row_valid_d[tgt_way] = 1'b0;
      end
      default: begin
        row_valid_d = row_valid;
        row_age_d   = row_age;
      end
    endcase
  end

  // Set storage: the INIT sweep owns the write port until IDLE, then accepted
  // state-changing requests write the addressed set on the accept edge.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      valid_q[set_cnt_q] <= '0;
      age_q[set_cnt_q]   <= init_age;
    end else if (row_wr) begin
      valid_q[req_index_i] <= row_valid_d;
      age_q[req_index_i]   <= row_age_d;
    end
  end

  // Control FSM with registered ready and response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_INIT;
      set_cnt_q   <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_empty_q <= 1'b0;
      rsp_evict_q <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_way_q   <= tgt_way;
        rsp_empty_q <= rsp_empty_d;
        rsp_evict_q <= rsp_evict_d;
      end
      case (state_q)
        ST_INIT: begin
          set_cnt_q <= set_cnt_q + 1'b1;
          if (set_cnt_q == SET_LAST) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_way_o   = rsp_way_q;
  assign rsp_empty_o = rsp_empty_q;
  assign rsp_evict_o = rsp_evict_q;

`ifdef ALLOC_PERF_CNT_EN
  logic [31:0] cnt_fill_empty_q;
  logic [31:0] cnt_evict_q;

  // Saturating outcome counters for accepted ALLOCs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_fill_empty_q <= '0;
      cnt_evict_q      <= '0;
    end else if (accept && req_op_i == OP_ALLOC) begin
      if (any_empty) begin
        if (cnt_fill_empty_q != 32'hFFFF_FFFF) begin
          cnt_fill_empty_q <= cnt_fill_empty_q + 32'd1;
        end
      end else begin
        if (cnt_evict_q != 32'hFFFF_FFFF) begin
          cnt_evict_q <= cnt_evict_q + 32'd1;
        end
      end
    end
  end

  assign cnt_fill_empty_o = cnt_fill_empty_q;
  assign cnt_evict_o      = cnt_evict_q;
`endif

endmodule

// File: tb/tb_way_alloc_unit.sv
// tb/tb_way_alloc_unit.sv - self-checking bench for way_alloc_unit with a recency-list model

module tb_way_alloc_unit;

  localparam int NW = 8;
  localparam int NS = 16;
  localparam int WW = 3;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [IW-1:0] req_index = '0;
  logic [WW-1:0] req_way = '0;
  logic          rsp_valid;
  logic [WW-1:0] rsp_way;
  logic          rsp_empty;
  logic          rsp_evict;
`ifdef ALLOC_PERF_CNT_EN
  logic [31:0]   cnt_fill_empty;
  logic [31:0]   cnt_evict;
`endif

  int total = 0;
  int bad = 0;

  way_alloc_unit #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_index_i      (req_index),
    .req_way_i        (req_way),
    .rsp_valid_o      (rsp_valid),
    .rsp_way_o        (rsp_way),
    .rsp_empty_o      (rsp_empty),
    .rsp_evict_o      (rsp_evict)
`ifdef ALLOC_PERF_CNT_EN
    ,
    .cnt_fill_empty_o (cnt_fill_empty),
    .cnt_evict_o      (cnt_evict)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: per set a recency list (index 0 = most recent) plus valid flags.
  int m_valid [NS][NW];
  int m_lst   [NS][NW];
  int m_fill;
  int m_evict;

  task automatic m_reset();
    for (int s = 0; s < NS; s++) begin
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 0;
        m_lst[s][w]   = w;
      end
    end
    m_fill  = 0;
    m_evict = 0;
  endtask

  task automatic m_front(input int s, input int w);
    int p = 0;
    for (int i = 0; i < NW; i++) if (m_lst[s][i] == w) p = i;
    for (int i = p; i > 0; i--) m_lst[s][i] = m_lst[s][i-1];
    m_lst[s][0] = w;
  endtask

  task automatic m_back(input int s, input int w);
    int p = 0;
    for (int i = 0; i < NW; i++) if (m_lst[s][i] == w) p = i;
    for (int i = p; i < NW - 1; i++) m_lst[s][i] = m_lst[s][i+1];
    m_lst[s][NW-1] = w;
  endtask

  task automatic m_apply(input int op, input int s, input int w,
                         output int ew, output int ee, output int ev);
    int empty = -1;
    for (int i = NW - 1; i >= 0; i--) if (m_valid[s][i] == 0) empty = i;
    ev = 0;
    case (op)
      0: begin
        if (empty >= 0) begin
          ew = empty; ee = 1; m_fill++;
        end else begin
          ew = m_lst[s][NW-1]; ee = 0; ev = 1; m_evict++;
        end
        m_valid[s][ew] = 1;
        m_front(s, ew);
      end
      1: begin
        ew = w; ee = (m_valid[s][w] == 0) ? 1 : 0;
        m_front(s, w);
      end
      2: begin
        ew = w; ee = (m_valid[s][w] == 0) ? 1 : 0;
        m_valid[s][w] = 0;
        m_back(s, w);
      end
      default: begin
        if (empty >= 0) begin
          ew = empty; ee = 1;
        end else begin
          ew = m_lst[s][NW-1]; ee = 0;
        end
      end
    endcase
  endtask

  // Drives one request for one cycle; samples the response 1 time unit after the accept edge.
  task automatic do_req(input int op, input int idx, input int way,
                        output logic ov, output logic [WW-1:0] ow,
                        output logic oe, output logic ox);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_index = IW'(idx);
    req_way   = WW'(way);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    ov = rsp_valid; ow = rsp_way; oe = rsp_empty; ox = rsp_evict;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_way !== '0 ||
        rsp_empty !== 1'b0 || rsp_evict !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got ready=%0b v=%0b way=%0d empty=%0b evict=%0b, want all 0",
               req_ready, rsp_valid, rsp_way, rsp_empty, rsp_evict);
    end
`ifdef ALLOC_PERF_CNT_EN
    total++;
    if (cnt_fill_empty !== 32'd0 || cnt_evict !== 32'd0) begin
      bad++;
      $display("FAIL reset_counters: got fill=%0d evict=%0d, want 0 0", cnt_fill_empty, cnt_evict);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int k = 1; k <= NS; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (req_ready !== 1'((k == NS) ? 1 : 0) || rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL init_sweep edge %0d: got ready=%0b v=%0b, want ready=%0b v=0",
                 k, req_ready, rsp_valid, (k == NS));
      end
    end
  endtask

  task automatic test_fill();
    logic ov, oe, ox;
    logic [WW-1:0] ow;
    int ew, ee, ev;
    int ops [11] = '{0, 0, 0, 0, 0, 0, 0, 3, 0, 3, 1};
    for (int i = 0; i < 11; i++) begin
      do_req(ops[i], 0, 0, ov, ow, oe, ox);
      m_apply(ops[i], 0, 0, ew, ee, ev);
      total++;
      if (ov !== 1'b1 || ow !== WW'(ew) || oe !== 1'(ee) || ox !== 1'(ev)) begin
        bad++;
        $display("FAIL fill step %0d op %0d: got v=%0b way=%0d empty=%0b evict=%0b, want v=1 way=%0d empty=%0d evict=%0d",
                 i, ops[i], ov, ow, oe, ox, ew, ee, ev);
      end
    end
    // After touching way 0 in a full set, the next ALLOC evicts the new LRU.
    do_req(0, 0, 0, ov, ow, oe, ox);
    m_apply(0, 0, 0, ew, ee, ev);
    total++;
    if (ov !== 1'b1 || ow !== WW'(ew) || oe !== 1'(ee) || ox !== 1'(ev) || ox !== 1'b1) begin
      bad++;
      $display("FAIL fill_evict: got v=%0b way=%0d empty=%0b evict=%0b, want v=1 way=%0d empty=%0d evict=1",
               ov, ow, oe, ox, ew, ee);
    end
    @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_way !== WW'(ew)) begin
      bad++;
      $display("FAIL rsp_hold: got v=%0b way=%0d, want v=0 way=%0d", rsp_valid, rsp_way, ew);
    end
  endtask

  task automatic test_inval();
    logic ov, oe, ox;
    logic [WW-1:0] ow;
    int ew, ee, ev;
    for (int i = 0; i < NW; i++) begin
      do_req(0, 3, 0, ov, ow, oe, ox);
      m_apply(0, 3, 0, ew, ee, ev);
    end
    total++;
    if (ow !== WW'(ew) || oe !== 1'(ee)) begin
      bad++;
      $display("FAIL inval_fill_last: got way=%0d empty=%0b, want way=%0d empty=%0d", ow, oe, ew, ee);
    end
    do_req(2, 3, 5, ov, ow, oe, ox);
    m_apply(2, 3, 5, ew, ee, ev);
    total++;
    if (ov !== 1'b1 || ow !== WW'(ew) || oe !== 1'(ee) || ox !== 1'(ev)) begin
      bad++;
      $display("FAIL inval_rsp: got v=%0b way=%0d empty=%0b evict=%0b, want v=1 way=%0d empty=%0d evict=%0d",
               ov, ow, oe, ox, ew, ee, ev);
    end
    do_req(0, 3, 0, ov, ow, oe, ox);
    m_apply(0, 3, 0, ew, ee, ev);
    total++;
    if (ov !== 1'b1 || ow !== WW'(ew) || oe !== 1'(ee) || ox !== 1'(ev)) begin
      bad++;
      $display("FAIL inval_realloc: got v=%0b way=%0d empty=%0b evict=%0b, want v=1 way=%0d empty=%0d evict=%0d",
               ov, ow, oe, ox, ew, ee, ev);
    end
    do_req(3, 0, 0, ov, ow, oe, ox);
    m_apply(3, 0, 0, ew, ee, ev);
    total++;
    if (ov !== 1'b1 || ow !== WW'(ew) || oe !== 1'(ee) || ox !== 1'(ev)) begin
      bad++;
      $display("FAIL inval_other_set: got v=%0b way=%0d empty=%0b evict=%0b, want v=1 way=%0d empty=%0d evict=%0d",
               ov, ow, oe, ox, ew, ee, ev);
    end
  endtask

  task automatic test_back_to_back();
    logic ov1, oe1, ox1, ov2, oe2, ox2, ov, oe, ox;
    logic [WW-1:0] ow1, ow2, ow;
    int ew1, ee1, ev1, ew2, ee2, ev2, ew, ee, ev;
    do_req(0, 7, 0, ov1, ow1, oe1, ox1);
    m_apply(0, 7, 0, ew1, ee1, ev1);
    do_req(0, 7, 0, ov2, ow2, oe2, ox2);
    m_apply(0, 7, 0, ew2, ee2, ev2);
    total++;
    if (ov1 !== 1'b1 || ov2 !== 1'b1 || ow1 === ow2 ||
        ow1 !== WW'(ew1) || ow2 !== WW'(ew2) || oe2 !== 1'(ee2)) begin
      bad++;
      $display("FAIL back_to_back: got v=%0b,%0b way=%0d,%0d empty2=%0b, want v=1,1 way=%0d,%0d empty2=%0d",
               ov1, ov2, ow1, ow2, oe2, ew1, ew2, ee2);
    end
    // Reset lands while a response is on the outputs.
    do_req(0, 7, 0, ov, ow, oe, ox);
    total++;
    if (ov !== 1'b1) begin
      bad++;
      $display("FAIL pre_abort_valid: got v=%0b, want 1", ov);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: got v=%0b ready=%0b, want v=0 ready=0", rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int k = 1; k <= NS; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (req_ready !== 1'((k == NS) ? 1 : 0)) begin
        bad++;
        $display("FAIL re_sweep edge %0d: got ready=%0b, want %0b", k, req_ready, (k == NS));
      end
    end
    do_req(3, 0, 0, ov, ow, oe, ox);
    m_apply(3, 0, 0, ew, ee, ev);
    total++;
    if (ov !== 1'b1 || ow !== WW'(ew) || oe !== 1'(ee) || ox !== 1'(ev)) begin
      bad++;
      $display("FAIL post_reset_query: got v=%0b way=%0d empty=%0b evict=%0b, want v=1 way=%0d empty=%0d evict=%0d",
               ov, ow, oe, ox, ew, ee, ev);
    end
  endtask

  task automatic test_random();
    logic ov, oe, ox;
    logic [WW-1:0] ow;
    int ew, ee, ev, op, idx, way;
    for (int i = 0; i < 400; i++) begin
      op  = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 3));
      way = int'($urandom_range(0, NW - 1));
      total++;
      if (req_ready !== 1'b1) begin
        bad++;
        $display("FAIL random_ready %0d: got ready=%0b, want 1", i, req_ready);
      end
      do_req(op, idx, way, ov, ow, oe, ox);
      m_apply(op, idx, way, ew, ee, ev);
      total++;
      if (ov !== 1'b1 || ow !== WW'(ew) || oe !== 1'(ee) || ox !== 1'(ev)) begin
        bad++;
        $display("FAIL random %0d op=%0d idx=%0d way=%0d: got v=%0b way=%0d empty=%0b evict=%0b, want v=1 way=%0d empty=%0d evict=%0d",
                 i, op, idx, way, ov, ow, oe, ox, ew, ee, ev);
      end
    end
  endtask

`ifdef ALLOC_PERF_CNT_EN
  task automatic test_perf();
    logic ov, oe, ox;
    logic [WW-1:0] ow;
    int ew, ee, ev;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (NS) @(posedge clk);
    for (int i = 0; i < NW + 3; i++) begin
      do_req(0, 5, 0, ov, ow, oe, ox);
      m_apply(0, 5, 0, ew, ee, ev);
    end
    total++;
    if (cnt_fill_empty !== 32'(m_fill) || cnt_evict !== 32'(m_evict)) begin
      bad++;
      $display("FAIL perf_counters: got fill=%0d evict=%0d, want fill=%0d evict=%0d",
               cnt_fill_empty, cnt_evict, m_fill, m_evict);
    end
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_fill();
    test_inval();
    test_back_to_back();
    test_random();
`ifdef ALLOC_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
